// File: rtl/sha_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sha_pkg
// Purpose : Shared types and constants for the SHA-256 message scheduler:
//           FSM state encoding, default round count, window depth and the
//           rotate/shift amounts of the small sigma functions.
// Revision: 1.0 - initial release
// ============================================================================
package sha_pkg;

  localparam int ROUNDS_DEF = 64;
  localparam int WIN_DEPTH  = 16;

  // sigma0 = ror7 ^ ror18 ^ shr3
  localparam int S0_ROT_A = 7;
  localparam int S0_ROT_B = 18;
  localparam int S0_SHR   = 3;

  // sigma1 = ror17 ^ ror19 ^ shr10
  localparam int S1_ROT_A = 17;
  localparam int S1_ROT_B = 19;
  localparam int S1_SHR   = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // Rotate right of a 32-bit word by a constant amount (1..31).
  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha_sigma.sv
`default_nettype none
// ============================================================================
// Module  : sha_sigma
// Purpose : Combinational SHA-256 small sigma of one 32-bit word. The two
//           rotate amounts and the shift amount select sigma0 or sigma1.
// Revision: 1.0 - initial release
// ============================================================================
module sha_sigma
  import sha_pkg::*;
#(
  parameter int ROT_A = S0_ROT_A,
  parameter int ROT_B = S0_ROT_B,
  parameter int SHR   = S0_SHR
) (
  input  logic [31:0] x,
  output logic [31:0] y
);

  // Pure XOR of two rotations and one logical shift.
  always_comb begin
    y = ror32(x, ROT_A) ^ ror32(x, ROT_B) ^ (x >> SHR);
  end

endmodule
`default_nettype wire

// File: rtl/sha_msg_sched.sv
`default_nettype none
// ============================================================================
// Module  : sha_msg_sched
// Purpose : SHA-256 message schedule generator. Sixteen message words are
//           loaded while idle; a start emits ROUNDS schedule words W[t], one
//           per cycle, from a 16-word circular window (W[t] overwrites
//           W[t-16] in place). hold_in freezes the schedule.
// Config  : SHA_SCHED_ERR_EN - when defined, a start with an incomplete load
//           pulses err_out and is refused; otherwise the start always runs
//           on whatever the window currently holds.
// Revision: 1.0 - initial release
// ============================================================================
module sha_msg_sched
  import sha_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_in,
  input  logic        load_in,
  input  logic [3:0]  load_idx_in,
  input  logic [31:0] w_in,
  input  logic        hold_in,
  output logic [31:0] w_out,
  output logic        w_valid_out,
  output logic [5:0]  t_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        err_out
);

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  sched_state_t state, state_nxt;
  logic [5:0]   t;
  logic [15:0]  loaded_mask;
  logic [31:0]  win [WIN_DEPTH];
  logic [15:0]  mask_upd;
  logic         start_ok;
  logic         advance;
  logic [3:0]   slot_m16, slot_m15, slot_m7, slot_m2;
  logic [31:0]  s0_val, s1_val, w_new, w_cur;

  // The start decision must see a load issued in the same cycle.
  assign mask_upd = loaded_mask | (load_in ? (16'd1 << load_idx_in) : 16'd0);

`ifdef SHA_SCHED_ERR_EN
  logic err_pulse;
  assign start_ok = (mask_upd == 16'hFFFF);
`else
  assign start_ok = 1'b1;
`endif

  assign advance = (state == RUN) && !hold_in;

  // Circular window: slot t mod 16 holds W[t-16], the others follow.
  assign slot_m16 = t[3:0];
  assign slot_m15 = t[3:0] + 4'd1;
  assign slot_m7  = t[3:0] + 4'd9;
  assign slot_m2  = t[3:0] + 4'd14;

  sha_sigma #(.ROT_A(S0_ROT_A), .ROT_B(S0_ROT_B), .SHR(S0_SHR)) u_sigma0 (
    .x (win[slot_m15]),
    .y (s0_val)
  );

  sha_sigma #(.ROT_A(S1_ROT_A), .ROT_B(S1_ROT_B), .SHR(S1_SHR)) u_sigma1 (
    .x (win[slot_m2]),
    .y (s1_val)
  );

  assign w_new = s1_val + win[slot_m7] + s0_val + win[slot_m16];
  assign w_cur = (t < 6'd16) ? win[slot_m16] : w_new;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; starts are only honoured while idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in && start_ok) state_nxt = RUN;
      RUN:     if (advance && (t == LAST_T)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; word data is shown only on valid cycles.
  always_comb begin
    busy_out    = (state == RUN);
    w_valid_out = advance;
    w_out       = advance ? w_cur : 32'd0;
    t_out       = (state == RUN) ? t : 6'd0;
    done_out    = (state == DONE);
`ifdef SHA_SCHED_ERR_EN
    err_out     = err_pulse;
`else
    err_out     = 1'b0;
`endif
  end

  // Round counter and load tracking; t returns to 0 after the last word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      t           <= 6'd0;
      loaded_mask <= 16'd0;
    end else begin
      if (advance)            t <= (t == LAST_T) ? 6'd0 : t + 6'd1;
      else if (state != RUN)  t <= 6'd0;
      if (state == IDLE)      loaded_mask <= mask_upd;
      else if (state == DONE) loaded_mask <= 16'd0;
    end
  end

  // Window storage: host writes while idle, schedule writes while running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < WIN_DEPTH; i++) win[i] <= 32'd0;
    end else if (state == IDLE) begin
      if (load_in) win[load_idx_in] <= w_in;
    end else if (advance && (t >= 6'd16)) begin
      win[slot_m16] <= w_new;
    end
  end

`ifdef SHA_SCHED_ERR_EN
  // One-cycle error pulse for a refused start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_pulse <= 1'b0;
    else        err_pulse <= (state == IDLE) && start_in && !start_ok;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha_msg_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_sha_msg_sched
// Purpose : Scoreboard bench for sha_msg_sched: stimulus pushes expected
//           (t, W[t]) pairs, a negedge monitor pops and compares them.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sha_msg_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_in, load_in, hold_in;
  logic [3:0]  load_idx_in;
  logic [31:0] w_in;
  logic [31:0] w_out;
  logic        w_valid_out, busy_out, done_out, err_out;
  logic [5:0]  t_out;

  typedef struct packed {
    logic [5:0]  t;
    logic [31:0] w;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          errors = 0;
  int          checks = 0;
  int          vcount = 0;
  int          done_cnt = 0;
  int          done_before;
  logic [31:0] got   [64];
  logic [31:0] blk   [16];
  logic [31:0] sched [64];

  always #5 clk = ~clk;

  sha_msg_sched #(.ROUNDS(64)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .start_in    (start_in),
    .load_in     (load_in),
    .load_idx_in (load_idx_in),
    .w_in        (w_in),
    .hold_in     (hold_in),
    .w_out       (w_out),
    .w_valid_out (w_valid_out),
    .t_out       (t_out),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .err_out     (err_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  // Reference small sigmas written with explicit bit slicing.
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
  endfunction

  task automatic compute_sched();
    for (int i = 0; i < 64; i++) begin
      if (i < 16) sched[i] = blk[i];
      else        sched[i] = ss1(sched[i-2]) + sched[i-7] + ss0(sched[i-15]) + sched[i-16];
    end
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [3:0] idx, input logic [31:0] d);
    load_in = 1'b1; load_idx_in = idx; w_in = d;
    tick();
    load_in = 1'b0;
  endtask

  task automatic load_abc(input int nwords);
    for (int i = 0; i < nwords; i++) load_word(4'(i), blk[i]);
  endtask

  task automatic start_run();
    compute_sched();
    for (int i = 0; i < 64; i++) exp_q.push_back({6'(i), sched[i]});
    vcount   = 0;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic wait_t(input logic [5:0] n);
    for (int i = 0; i < 200; i++) begin
      if (busy_out && t_out == n) break;
      tick();
    end
    check("reach_t", {26'd0, t_out}, {26'd0, n});
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 200; i++) begin
      if (done_out) break;
      tick();
    end
    check({name, "_done"}, {31'd0, done_out}, 32'd1);
    check({name, "_busy_at_done"}, {31'd0, busy_out}, 32'd0);
    check({name, "_valid_count"}, 32'(vcount), 32'd64);
    check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    tick();
    check({name, "_done_pulse_end"}, {31'd0, done_out}, 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_w_out"},   w_out, 32'd0);
    check({name, "_valid"},   {31'd0, w_valid_out}, 32'd0);
    check({name, "_t_out"},   {26'd0, t_out}, 32'd0);
    check({name, "_busy"},    {31'd0, busy_out}, 32'd0);
    check({name, "_done"},    {31'd0, done_out}, 32'd0);
    check({name, "_err"},     {31'd0, err_out}, 32'd0);
  endtask

  // Monitor: every valid word is matched against the scoreboard head.
  always @(negedge clk) begin
    if (done_out) done_cnt++;
    if (w_valid_out) begin
      vcount++;
      got[t_out] = w_out;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual t=%0d w=0x%08h required=no word", t_out, w_out);
      end else begin
        e = exp_q.pop_front();
        check("t_out", {26'd0, t_out}, {26'd0, e.t});
        check("w_out", w_out, e.w);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start_in = 1'b0; load_in = 1'b0; hold_in = 1'b0;
    load_idx_in = 4'd0; w_in = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    tick();

    // Run A: plain "abc" block with hand-computed early words.
    set_abc();
    load_abc(16);
    start_run();
    check("first_valid_latency", {31'd0, busy_out}, 32'd1);
    wait_done("runA");
    check("abc_W16", got[16], 32'h61626380);
    check("abc_W17", got[17], 32'h000F0000);
    check("abc_W18", got[18], 32'h7DA86405);

    // Run B: stray load/start at t=10, hold for 3 cycles at t=20.
    load_abc(16);
    start_run();
    wait_t(6'd10);
    start_in = 1'b1; load_in = 1'b1; load_idx_in = 4'd3; w_in = 32'hDEADBEEF;
    tick();
    start_in = 1'b0; load_in = 1'b0;
    wait_t(6'd20);
    hold_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_valid", {31'd0, w_valid_out}, 32'd0);
      check("hold_t", {26'd0, t_out}, 32'd20);
      check("hold_busy", {31'd0, busy_out}, 32'd1);
      tick();
    end
    hold_in = 1'b0;
    wait_done("runB");

    // Run C: reset at t=30 aborts without done.
    load_abc(16);
    start_run();
    wait_t(6'd30);
    done_before = done_cnt;
    reset = 1'b0;
    #1;
    check_all_zero("midrun_reset");
    exp_q.delete();
    tick();
    tick();
    reset = 1'b1;
    repeat (4) tick();
    check("no_done_after_abort", 32'(done_cnt), 32'(done_before));
    check("idle_after_abort", {31'd0, busy_out}, 32'd0);

    // Run D: fresh load after abort.
    load_abc(16);
    start_run();
    wait_done("runD");
    check("abcD_W18", got[18], 32'h7DA86405);

    // Run E: only 15 words loaded after reset.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    load_abc(15);
`ifdef SHA_SCHED_ERR_EN
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    check("err_pulse", {31'd0, err_out}, 32'd1);
    check("err_busy", {31'd0, busy_out}, 32'd0);
    tick();
    check("err_pulse_end", {31'd0, err_out}, 32'd0);
    check("err_stay_idle", {31'd0, busy_out}, 32'd0);
    load_word(4'd15, blk[15]);
    start_run();
    wait_done("runE");
`else
    blk[15] = 32'd0;
    start_run();
    check("noerr_err", {31'd0, err_out}, 32'd0);
    check("noerr_busy", {31'd0, busy_out}, 32'd1);
    wait_done("runE");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
